// File: rtl/chess_clock_scheduler.sv
// Two-player chess clock: two BCD time banks sharing one decrement datapath,
// move-driven ownership switching, Fischer increment and time-out flagging.
module chess_clock_scheduler #(
  parameter logic [7:0] PRESET_MIN = 8'h05,
  parameter logic [7:0] PRESET_SEC = 8'h00,
  parameter logic [5:0] INC_SEC    = 6'd0
) (
  input  logic       clk_core,
  input  logic       rst,
  input  logic       tick_10ms,
  input  logic       btn_p0,
  input  logic       btn_p1,
  input  logic       btn_pause,
  input  logic       clr,
  input  logic       load_en,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  output logic [7:0] min_o,
  output logic [7:0] sec_o,
  output logic [7:0] ms_10_o,
  output logic       active_o,
  output logic [2:0] state_o,
  output logic [1:0] flag_o,
  output logic       time_out_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    FLAG  = 3'd3
  } state_t;

  localparam logic [23:0] PRESET = {PRESET_MIN, PRESET_SEC, 8'h00};

  // Bank layout: {min, sec, ms_10}, all BCD.
  logic [23:0] bank_q [2];
  logic [23:0] disp_q;
  state_t      state_q;
  logic        active_q;
  logic [1:0]  flag_q;
  logic        time_out_q;

  logic [23:0] act_bank, dec_v, inc_v;
  logic        hit_zero, move;

  // Two-digit BCD decrement; result is {borrow, value}, wrapping to {hi_wrap,9}.
  function automatic logic [8:0] dec2(input logic [7:0] v, input logic [3:0] hi_wrap);
    if (v == 8'h00)
      return {1'b1, hi_wrap, 4'h9};
    else if (v[3:0] == 4'h0)
      return {1'b0, v[7:4] - 4'h1, 4'h9};
    else
      return {1'b0, v - 8'h01};
  endfunction

  function automatic logic [23:0] bcd_dec(input logic [23:0] t);
    logic [8:0] m, s, n;
    if (t == '0)
      return '0;
    n = dec2(t[7:0], 4'h9);
    s = n[8] ? dec2(t[15:8], 4'h5) : {1'b0, t[15:8]};
    m = s[8] ? dec2(t[23:16], 4'h9) : {1'b0, t[23:16]};
    return {m[7:0], s[7:0], n[7:0]};
  endfunction

  // Seconds go through binary so any INC_SEC up to 59 needs at most one carry.
  function automatic logic [23:0] bcd_inc(input logic [23:0] t);
    logic [6:0] s;
    logic [7:0] mn;
    s = 7'(t[15:12]) * 7'd10 + 7'(t[11:8]) + 7'(INC_SEC);
    if (s < 7'd60)
      return {t[23:16], 4'(s / 7'd10), 4'(s % 7'd10), t[7:0]};
    s = s - 7'd60;
    if (t[23:16] == 8'h99)
      return 24'h995999;
    mn = (t[19:16] == 4'h9) ? {t[23:20] + 4'h1, 4'h0} : t[23:16] + 8'h01;
    return {mn, 4'(s / 7'd10), 4'(s % 7'd10), t[7:0]};
  endfunction

  always_comb begin
    act_bank = bank_q[active_q];
    dec_v    = tick_10ms ? bcd_dec(act_bank) : act_bank;
    hit_zero = tick_10ms && (dec_v == '0);
    inc_v    = bcd_inc(dec_v);
    move     = active_q ? btn_p1 : btn_p0;
  end

  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      bank_q[0]  <= PRESET;
      bank_q[1]  <= PRESET;
      disp_q     <= PRESET;
      state_q    <= IDLE;
      active_q   <= 1'b0;
      flag_q     <= '0;
      time_out_q <= 1'b0;
    end else begin
      disp_q <= bank_q[active_q];
      if (clr) begin
        bank_q[0]  <= PRESET;
        bank_q[1]  <= PRESET;
        state_q    <= IDLE;
        active_q   <= 1'b0;
        flag_q     <= '0;
        time_out_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (load_en) begin
              bank_q[0] <= {load_min, load_sec, 8'h00};
              bank_q[1] <= {load_min, load_sec, 8'h00};
            end
            if (btn_p0) begin
              state_q  <= RUN;
              active_q <= 1'b1;
            end else if (btn_p1) begin
              state_q  <= RUN;
              active_q <= 1'b0;
            end
          end
          RUN: begin
            // Decrement is applied first; a zero result overrides pause and move.
            if (hit_zero) begin
              bank_q[active_q] <= '0;
              state_q          <= FLAG;
              flag_q[active_q] <= 1'b1;
              time_out_q       <= 1'b1;
            end else if (btn_pause) begin
              bank_q[active_q] <= dec_v;
              state_q          <= PAUSE;
            end else if (move) begin
              bank_q[active_q] <= inc_v;
              active_q         <= ~active_q;
            end else begin
              bank_q[active_q] <= dec_v;
            end
          end
          PAUSE: begin
            if (btn_pause)
              state_q <= RUN;
          end
          default: ;
        endcase
      end
    end
  end

  assign min_o      = disp_q[23:16];
  assign sec_o      = disp_q[15:8];
  assign ms_10_o    = disp_q[7:0];
  assign active_o   = active_q;
  assign state_o    = state_q;
  assign flag_o     = flag_q;
  assign time_out_o = time_out_q;

endmodule
